// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: holds one decoded pair and issues it to the even/odd
// pipes, gated by a per-register write-latency scoreboard.
module issue_scheduler #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        pair_valid,
  output logic                        pair_ready,
  input  logic                        s0_pipe,
  input  logic                        s1_pipe,
  input  logic [2:0]                  s0_src_en,
  input  logic [2:0]                  s1_src_en,
  input  logic [$clog2(NUM_REGS)-1:0] s0_ra,
  input  logic [$clog2(NUM_REGS)-1:0] s0_rb,
  input  logic [$clog2(NUM_REGS)-1:0] s0_rc,
  input  logic [$clog2(NUM_REGS)-1:0] s0_rt,
  input  logic [$clog2(NUM_REGS)-1:0] s1_ra,
  input  logic [$clog2(NUM_REGS)-1:0] s1_rb,
  input  logic [$clog2(NUM_REGS)-1:0] s1_rc,
  input  logic [$clog2(NUM_REGS)-1:0] s1_rt,
  input  logic [LAT_W-1:0]            s0_lat,
  input  logic [LAT_W-1:0]            s1_lat,
  output logic                        ep_valid,
  output logic                        ep_sel,
  output logic                        op_valid,
  output logic                        op_sel,
  output logic                        hold_busy
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {EMPTY, BOTH, ONLY1} state_t;

  typedef struct packed {
    logic             pipe;
    logic [2:0]       en;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [AW-1:0]    rc;
    logic [AW-1:0]    rt;
    logic [LAT_W-1:0] lat;
  } slot_t;

  state_t           r_state;
  slot_t            r_h0, r_h1;
  logic [LAT_W-1:0] r_cnt [NUM_REGS];

  logic w_ok0, w_ok1, w_haz, w_iss0, w_iss1, w_done;

  // Source-enable bit order is {ra, rb, rc}; the rt check guards against WAW.
  function automatic logic sb_ok(input slot_t s);
    return (!s.en[2] || r_cnt[s.ra] == '0) &&
           (!s.en[1] || r_cnt[s.rb] == '0) &&
           (!s.en[0] || r_cnt[s.rc] == '0) &&
           (s.lat == '0 || r_cnt[s.rt] == '0);
  endfunction

  always_comb begin
    w_ok0  = sb_ok(r_h0);
    w_ok1  = sb_ok(r_h1);
    w_haz  = (r_h0.lat != '0) &&
             ((r_h1.en[2] && r_h1.ra == r_h0.rt) ||
              (r_h1.en[1] && r_h1.rb == r_h0.rt) ||
              (r_h1.en[0] && r_h1.rc == r_h0.rt) ||
              (r_h1.lat != '0 && r_h1.rt == r_h0.rt));
    w_iss0 = 1'b0;
    w_iss1 = 1'b0;
    if (!flush) begin
      if (r_state == BOTH) begin
        w_iss0 = w_ok0;
        w_iss1 = w_ok0 && w_ok1 && (r_h0.pipe != r_h1.pipe) && !w_haz;
      end else if (r_state == ONLY1) begin
        w_iss1 = w_ok1;
      end
    end
    w_done = w_iss1;
  end

  assign pair_ready = rst && !flush && (r_state == EMPTY || w_done);
  assign hold_busy  = (r_state != EMPTY);
  assign ep_valid   = (w_iss0 && !r_h0.pipe) || (w_iss1 && !r_h1.pipe);
  assign ep_sel     = w_iss1 && !r_h1.pipe;
  assign op_valid   = (w_iss0 && r_h0.pipe) || (w_iss1 && r_h1.pipe);
  assign op_sel     = w_iss1 && r_h1.pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_h0    <= '0;
      r_h1    <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (pair_ready && pair_valid) begin
      r_state <= BOTH;
      r_h0    <= '{s0_pipe, s0_src_en, s0_ra, s0_rb, s0_rc, s0_rt, s0_lat};
      r_h1    <= '{s1_pipe, s1_src_en, s1_ra, s1_rb, s1_rc, s1_rt, s1_lat};
    end else if (w_done) begin
      r_state <= EMPTY;
    end else if (r_state == BOTH && w_iss0) begin
      r_state <= ONLY1;
    end
  end

  // A dual issue never loads the same rt twice: the intra-pair hazard blocks it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - LAT_W'(1);
      if (w_iss0 && r_h0.lat != '0) r_cnt[r_h0.rt] <= r_h0.lat;
      if (w_iss1 && r_h1.lat != '0) r_cnt[r_h1.rt] <= r_h1.lat;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, checked against a
// model that tracks the cycle at which each register becomes free.
module tb_issue_scheduler;
  typedef struct packed {
    logic       pipe;
    logic [2:0] en;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [6:0] rt;
    logic [2:0] lat;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst, flush, pair_valid;
  instr_t d0, d1;
  logic   pair_ready, ep_valid, ep_sel, op_valid, op_sel, hold_busy;

  int n_checks = 0;
  int n_errors = 0;

  // model: hold_n = 0 empty, 2 both pending, 1 only slot 1 pending
  int     hold_n = 0;
  instr_t h0, h1;
  int     ready_t [128];
  int     t = 0;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .s0_pipe(d0.pipe), .s1_pipe(d1.pipe),
    .s0_src_en(d0.en), .s1_src_en(d1.en),
    .s0_ra(d0.ra), .s0_rb(d0.rb), .s0_rc(d0.rc), .s0_rt(d0.rt),
    .s1_ra(d1.ra), .s1_rb(d1.rb), .s1_rc(d1.rc), .s1_rt(d1.rt),
    .s0_lat(d0.lat), .s1_lat(d1.lat),
    .ep_valid(ep_valid), .ep_sel(ep_sel),
    .op_valid(op_valid), .op_sel(op_sel),
    .hold_busy(hold_busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic p, input logic [2:0] en, input int ra, input int rb,
                                input int rc, input int rt, input int lat);
    return '{p, en, 7'(ra), 7'(rb), 7'(rc), 7'(rt), 3'(lat)};
  endfunction

  function automatic bit free_r(input logic [6:0] r);
    return t >= ready_t[r];
  endfunction

  function automatic bit ok(input instr_t s);
    return (!s.en[2] || free_r(s.ra)) && (!s.en[1] || free_r(s.rb)) &&
           (!s.en[0] || free_r(s.rc)) && (s.lat == 0 || free_r(s.rt));
  endfunction

  function automatic bit raw_waw(input instr_t a, input instr_t b);
    if (a.lat == 0) return 0;
    return (b.en[2] && b.ra == a.rt) || (b.en[1] && b.rb == a.rt) ||
           (b.en[0] && b.rc == a.rt) || (b.lat != 0 && b.rt == a.rt);
  endfunction

  task automatic step(input logic fl, input logic pv, input instr_t a, input instr_t b);
    bit iss0, iss1, rdy;
    @(posedge clk); #1;
    flush = fl; pair_valid = pv; d0 = a; d1 = b;
    #1;
    iss0 = 0; iss1 = 0;
    if (!fl && hold_n == 2) begin
      iss0 = ok(h0);
      iss1 = iss0 && ok(h1) && (h0.pipe != h1.pipe) && !raw_waw(h0, h1);
    end else if (!fl && hold_n == 1) begin
      iss1 = ok(h1);
    end
    rdy = !fl && (hold_n == 0 || iss1);
    check("pair_ready", pair_ready, rdy);
    check("hold_busy",  hold_busy, hold_n != 0);
    check("ep_valid",   ep_valid, (iss0 && !h0.pipe) || (iss1 && !h1.pipe));
    check("ep_sel",     ep_sel, iss1 && !h1.pipe);
    check("op_valid",   op_valid, (iss0 && h0.pipe) || (iss1 && h1.pipe));
    check("op_sel",     op_sel, iss1 && h1.pipe);
    if (iss0 && h0.lat != 0) ready_t[h0.rt] = t + 1 + int'(h0.lat);
    if (iss1 && h1.lat != 0) ready_t[h1.rt] = t + 1 + int'(h1.lat);
    if (fl) hold_n = 0;
    else if (rdy && pv) begin hold_n = 2; h0 = a; h1 = b; end
    else if (iss1) hold_n = 0;
    else if (hold_n == 2 && iss0) hold_n = 1;
    t++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; pair_valid = 1'b0;
    #1;
    check("rst_pair_ready", pair_ready, 1'b0);
    check("rst_hold_busy",  hold_busy, 1'b0);
    check("rst_ep_valid",   ep_valid, 1'b0);
    check("rst_op_valid",   op_valid, 1'b0);
    check("rst_ep_sel",     ep_sel, 1'b0);
    check("rst_op_sel",     op_sel, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_ready", pair_ready, 1'b1);
    hold_n = 0;
    foreach (ready_t[i]) ready_t[i] = 0;
    t += 2;
  endtask

  instr_t idle, ra, rb;

  initial begin
    idle = mk(0, 3'b000, 0, 0, 0, 0, 0);
    rst = 1'b0; flush = 1'b0; pair_valid = 1'b0; d0 = idle; d1 = idle;
    foreach (ready_t[i]) ready_t[i] = 0;
    #2;
    check("init_pair_ready", pair_ready, 1'b0);
    check("init_hold_busy",  hold_busy, 1'b0);
    #11 rst = 1'b1;

    // independent dual issue
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 5, 2), mk(1, 3'b000, 0, 0, 0, 6, 3));
    step(0, 0, idle, idle);
    step(0, 0, idle, idle);
    // pipe conflict: both even
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 11, 1), mk(0, 3'b000, 0, 0, 0, 12, 1));
    repeat (3) step(0, 0, idle, idle);
    // intra-pair RAW on r10
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 10, 4), mk(1, 3'b100, 10, 0, 0, 13, 0));
    repeat (8) step(0, 0, idle, idle);
    // scoreboard across pairs on r20, reader offered while the writer issues
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 20, 6), mk(1, 3'b000, 0, 0, 0, 21, 0));
    step(0, 1, mk(0, 3'b010, 0, 20, 0, 22, 1), mk(1, 3'b000, 0, 0, 0, 23, 0));
    repeat (9) step(0, 0, idle, idle);
    // flush while only slot 1 pending; r30 keeps counting
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 30, 5), mk(1, 3'b001, 0, 0, 30, 31, 0));
    step(0, 0, idle, idle);
    step(1, 0, idle, idle);
    step(0, 1, mk(1, 3'b100, 30, 0, 0, 32, 0), idle);
    repeat (6) step(0, 0, idle, idle);
    // async reset with r7 pending, then read r7
    step(0, 1, mk(0, 3'b000, 0, 0, 0, 7, 5), mk(1, 3'b000, 0, 0, 0, 8, 0));
    step(0, 0, idle, idle);
    step(0, 0, idle, idle);
    do_reset();
    step(0, 1, mk(0, 3'b100, 7, 0, 0, 9, 0), mk(1, 3'b000, 0, 0, 0, 14, 0));
    step(0, 0, idle, idle);

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      ra = mk($urandom_range(0, 1), 3'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      rb = mk($urandom_range(0, 1), 3'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
